// File: rtl/id_issue_queue.sv
// rtl/id_issue_queue.sv - in-order decode-to-issue queue with side-unit dispatch
// Head entry dispatches to its side unit first, then issues to EX once that dispatch completes.
module id_issue_queue #(
  parameter int PAYLOAD_W = 128,
  parameter int DEPTH     = 2,
  parameter int NUM_FU    = 3
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         flush,
  input  logic                         valid_in,
  output logic                         ready_out,
  input  logic [PAYLOAD_W-1:0]         payload_in,
  input  logic [NUM_FU-1:0]            fu_sel_in,
  input  logic                         serialize_in,
  output logic                         valid_out,
  input  logic                         ready_in,
  output logic [PAYLOAD_W-1:0]         payload_out,
  output logic [NUM_FU-1:0]            fu_sel_out,
  output logic [NUM_FU-1:0]            fu_valid_out,
  input  logic [NUM_FU-1:0]            fu_ready_in,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [PAYLOAD_W-1:0] payload_mem [DEPTH];
  logic [NUM_FU-1:0]    sel_mem     [DEPTH];
  logic [NUM_FU-1:0]    pending     [DEPTH];
  logic [DEPTH-1:0]     ser_bits;
  logic [PTR_W-1:0]     wr_ptr;
  logic [PTR_W-1:0]     rd_ptr;
  logic [CNT_W-1:0]     occ;

  logic                 empty;
  logic                 full;
  logic                 ser_block;
  logic [NUM_FU-1:0]    sel_onehot;
  logic [NUM_FU-1:0]    head_pending;
  logic [NUM_FU-1:0]    fire;
  logic                 accept;
  logic                 pop;

  assign empty        = (occ == '0);
  assign full         = (occ == FULL_CNT);
  // Serialize bits are cleared on pop, so the block holds through the popping cycle.
  assign ser_block    = |ser_bits;
  assign sel_onehot   = fu_sel_in & (~fu_sel_in + NUM_FU'(1));
  assign head_pending = pending[rd_ptr];
  assign fire         = fu_valid_out & fu_ready_in;

  assign ready_out    = reset_n && !full && !ser_block && !flush;
  assign fu_valid_out = (!empty && !flush) ? head_pending : '0;
  assign valid_out    = !empty && !flush && ((head_pending & ~fire) == '0);
  assign payload_out  = empty ? '0 : payload_mem[rd_ptr];
  assign fu_sel_out   = empty ? '0 : sel_mem[rd_ptr];
  assign count        = occ;

  assign accept       = valid_in && ready_out;
  assign pop          = valid_out && ready_in;

  always_ff @(posedge clk) begin
    if (accept) begin
      payload_mem[wr_ptr] <= payload_in;
      sel_mem[wr_ptr]     <= sel_onehot;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      occ      <= '0;
      ser_bits <= '0;
      for (int i = 0; i < DEPTH; i++) pending[i] <= '0;
    end else if (flush) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      occ      <= '0;
      ser_bits <= '0;
      for (int i = 0; i < DEPTH; i++) pending[i] <= '0;
    end else begin
      if (!empty) pending[rd_ptr] <= head_pending & ~fire;
      if (pop) begin
        rd_ptr           <= rd_ptr + PTR_W'(1);
        ser_bits[rd_ptr] <= 1'b0;
        pending[rd_ptr]  <= '0;
      end
      if (accept) begin
        wr_ptr           <= wr_ptr + PTR_W'(1);
        ser_bits[wr_ptr] <= serialize_in;
        pending[wr_ptr]  <= sel_onehot;
      end
      if (accept && !pop)      occ <= occ + CNT_W'(1);
      else if (pop && !accept) occ <= occ - CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_id_issue_queue.sv
// tb/tb_id_issue_queue.sv - randomized and directed bench for id_issue_queue
// Outputs are compared every cycle against a queue-based reference model.
module tb_id_issue_queue;

  localparam int PW    = 128;
  localparam int DEPTH = 2;
  localparam int NF    = 3;
  localparam int CW    = $clog2(DEPTH+1);

  logic          clk = 1'b0;
  logic          reset_n;
  logic          flush;
  logic          valid_in;
  logic          ready_out;
  logic [PW-1:0] payload_in;
  logic [NF-1:0] fu_sel_in;
  logic          serialize_in;
  logic          valid_out;
  logic          ready_in;
  logic [PW-1:0] payload_out;
  logic [NF-1:0] fu_sel_out;
  logic [NF-1:0] fu_valid_out;
  logic [NF-1:0] fu_ready_in;
  logic [CW-1:0] count;

  id_issue_queue #(.PAYLOAD_W(PW), .DEPTH(DEPTH), .NUM_FU(NF)) dut (
    .clk(clk), .reset_n(reset_n), .flush(flush),
    .valid_in(valid_in), .ready_out(ready_out),
    .payload_in(payload_in), .fu_sel_in(fu_sel_in), .serialize_in(serialize_in),
    .valid_out(valid_out), .ready_in(ready_in),
    .payload_out(payload_out), .fu_sel_out(fu_sel_out),
    .fu_valid_out(fu_valid_out), .fu_ready_in(fu_ready_in),
    .count(count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [PW-1:0] pl;
    logic [NF-1:0] sel;
    logic          ser;
    logic [NF-1:0] pend;
  } ent_t;

  ent_t q[$];
  int checks = 0;
  int errors = 0;

  logic          m_rdy;
  logic          m_vout;
  logic [NF-1:0] m_fuv;
  logic [NF-1:0] m_fired;

  task automatic check(input string tag, input logic [PW-1:0] obs, input logic [PW-1:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [NF-1:0] lowest(input logic [NF-1:0] s);
    logic [NF-1:0] r;
    r = '0;
    for (int k = 0; k < NF; k++)
      if (s[k] && r == '0) r[k] = 1'b1;
    return r;
  endfunction

  function automatic logic [PW-1:0] rnd_payload();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic eval_model();
    logic          any_ser;
    logic [NF-1:0] hp;
    any_ser = 1'b0;
    foreach (q[i]) if (q[i].ser) any_ser = 1'b1;
    hp      = (q.size() > 0) ? q[0].pend : '0;
    m_rdy   = reset_n && (q.size() < DEPTH) && !any_ser && !flush;
    m_fuv   = (q.size() > 0 && !flush) ? hp : '0;
    m_fired = m_fuv & fu_ready_in;
    m_vout  = (q.size() > 0) && !flush && ((hp & ~m_fired) == '0);
  endtask

  task automatic compare_all();
    check("ready_out",    PW'(ready_out),    PW'(m_rdy));
    check("valid_out",    PW'(valid_out),    PW'(m_vout));
    check("fu_valid_out", PW'(fu_valid_out), PW'(m_fuv));
    check("count",        PW'(count),        PW'(q.size()));
    check("payload_out",  payload_out,       (q.size() > 0) ? q[0].pl : '0);
    check("fu_sel_out",   PW'(fu_sel_out),   (q.size() > 0) ? PW'(q[0].sel) : '0);
  endtask

  task automatic update_model();
    ent_t e;
    if (flush) begin
      q.delete();
    end else begin
      if (q.size() > 0) q[0].pend = q[0].pend & ~m_fired;
      if (m_vout && ready_in) void'(q.pop_front());
      if (valid_in && m_rdy) begin
        e.pl   = payload_in;
        e.sel  = lowest(fu_sel_in);
        e.ser  = serialize_in;
        e.pend = lowest(fu_sel_in);
        q.push_back(e);
      end
    end
  endtask

  // Called just after a rising edge; applies inputs, checks at the falling edge, advances one clock.
  task automatic step(input logic vin, input logic [PW-1:0] pl, input logic [NF-1:0] sel,
                      input logic ser, input logic rin, input logic [NF-1:0] frdy, input logic fl);
    valid_in = vin; payload_in = pl; fu_sel_in = sel; serialize_in = ser;
    ready_in = rin; fu_ready_in = frdy; flush = fl;
    @(negedge clk);
    eval_model();
    compare_all();
    @(posedge clk);
    update_model();
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_valid_out"},    PW'(valid_out),    '0);
    check({tag, "_fu_valid_out"}, PW'(fu_valid_out), '0);
    check({tag, "_ready_out"},    PW'(ready_out),    '0);
    check({tag, "_payload_out"},  payload_out,       '0);
    check({tag, "_fu_sel_out"},   PW'(fu_sel_out),   '0);
    check({tag, "_count"},        PW'(count),        '0);
  endtask

  initial begin
    reset_n = 1'b0; flush = 1'b0; valid_in = 1'b0; payload_in = '0; fu_sel_in = '0;
    serialize_in = 1'b0; ready_in = 1'b0; fu_ready_in = '0;
    #1;
    check_reset_outputs("rst");
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;

    // Plain ALU entries stream through with one-cycle latency.
    step(1'b1, PW'(128'hA), '0, 1'b0, 1'b1, '0, 1'b0);
    check("alu_count1", PW'(count), PW'(1));
    step(1'b1, PW'(128'hB), '0, 1'b0, 1'b1, '0, 1'b0);
    check("alu_count2", PW'(count), PW'(1));
    check("alu_payload_b", payload_out, PW'(128'hB));
    step(1'b0, '0, '0, 1'b0, 1'b1, '0, 1'b0);

    // Backpressure: third offer is refused at full.
    for (int i = 0; i < 3; i++) step(1'b1, PW'(16'hC00 + i), '0, 1'b0, 1'b0, '0, 1'b0);
    check("full_count", PW'(count), PW'(2));
    check("full_ready", PW'(ready_out), '0);
    step(1'b0, '0, '0, 1'b0, 1'b1, '0, 1'b0);
    check("drain_count", PW'(count), PW'(1));
    check("drain_ready", PW'(ready_out), PW'(1));
    step(1'b0, '0, '0, 1'b0, 1'b1, '0, 1'b0);

    // Side-unit dispatch holds the head until the unit accepts it.
    step(1'b1, PW'(128'hD), 3'b010, 1'b0, 1'b1, '0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, '0, '0, 1'b0, 1'b1, '0, 1'b0);
      check("fu_hold_valid", PW'(fu_valid_out), PW'(3'b010));
      check("fu_hold_vout", PW'(valid_out), '0);
    end
    step(1'b0, '0, '0, 1'b0, 1'b1, 3'b010, 1'b0);
    check("fu_done_fuv", PW'(fu_valid_out), '0);
    check("fu_done_count", PW'(count), '0);

    // Serializing entry blocks intake until it pops.
    step(1'b1, PW'(128'hE), 3'b110, 1'b1, 1'b0, '0, 1'b0);
    step(1'b1, PW'(128'hF), '0, 1'b0, 1'b0, '0, 1'b0);
    check("ser_block", PW'(ready_out), '0);
    step(1'b0, '0, '0, 1'b0, 1'b1, 3'b010, 1'b0);
    check("ser_release", PW'(ready_out), PW'(1));
    check("ser_count", PW'(count), '0);

    // Flush with a full queue and a simultaneous offer.
    step(1'b1, PW'(128'h6), 3'b001, 1'b0, 1'b0, '0, 1'b0);
    step(1'b1, PW'(128'h7), '0, 1'b0, 1'b0, '0, 1'b0);
    step(1'b1, PW'(128'h8), '0, 1'b0, 1'b1, 3'b001, 1'b1);
    check("flush_count", PW'(count), '0);
    step(1'b0, '0, '0, 1'b0, 1'b1, '0, 1'b0);

    // Reset asserted in the middle of a dispatch.
    step(1'b1, PW'(128'h9), 3'b100, 1'b0, 1'b0, '0, 1'b0);
    fu_ready_in = 3'b100; ready_in = 1'b1; valid_in = 1'b1;
    reset_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    q.delete();
    @(posedge clk);
    #1;
    reset_n = 1'b1;

    // Fill/drain cycles exercising pointer wrap-around.
    for (int i = 0; i < 12; i++) step(1'b1, PW'(32'h100 + i), '0, 1'b0, i[0], '0, 1'b0);
    for (int i = 0; i < 3; i++)  step(1'b0, '0, '0, 1'b0, 1'b1, '0, 1'b0);

    // Randomized traffic.
    for (int i = 0; i < 2000; i++)
      step($urandom_range(3, 0) != 0, rnd_payload(), NF'($urandom_range(7, 0)),
           $urandom_range(15, 0) == 0, $urandom_range(1, 0) == 1,
           NF'($urandom_range(7, 0)), $urandom_range(31, 0) == 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/id_issue_queue.md
ID_ISSUE_QUEUE -- requirements
Module: id_issue_queue

Interface
REQ-001 SHALL have parameter PAYLOAD_W, default 128, width of one decoded-instruction payload.
REQ-002 SHALL have parameter DEPTH, default 2, entry count; power of two, >= 2.
REQ-003 SHALL have parameter NUM_FU, default 3, number of side functional-unit dispatch channels (mul, div, fpu).
REQ-004 SHALL have ports: clk  in  1  clock, all state on rising edge; one clock domain.
REQ-005 SHALL have ports: reset_n  in  1  asynchronous, active-low reset.
REQ-006 SHALL have ports: flush  in  1  synchronous pipeline flush.
REQ-007 SHALL have ports: valid_in  in  1 / ready_out  out  1  upstream handshake.
REQ-008 SHALL have ports: payload_in  in  PAYLOAD_W  decoded payload.
REQ-009 SHALL have ports: fu_sel_in  in  NUM_FU  target side unit, one-hot or zero.
REQ-010 SHALL have ports: serialize_in  in  1  entry is serializing (CSR access).
REQ-011 SHALL have ports: valid_out  out  1 / ready_in  in  1  main EX handshake.
REQ-012 SHALL have ports: payload_out  out  PAYLOAD_W / fu_sel_out  out  NUM_FU  head entry contents.
REQ-013 SHALL have ports: fu_valid_out  out  NUM_FU / fu_ready_in  in  NUM_FU  per-unit dispatch handshakes.
REQ-014 SHALL have ports: count  out  $clog2(DEPTH+1)  occupied entries.

Function
REQ-015 SHALL store entries in a circular buffer with write/read pointers wrapping DEPTH-1 -> 0.
REQ-016 SHALL accept an entry when valid_in && ready_out, storing payload_in, fu_sel_in, serialize_in and setting the entry's pending mask to fu_sel_in.
REQ-017 SHALL keep only the lowest set bit of fu_sel_in when more than one bit is set.
REQ-018 SHALL drive ready_out = !full && !ser_block && !flush; ready_out SHALL NOT depend combinationally on ready_in or fu_ready_in.
REQ-019 SHALL assert ser_block while any occupied entry has its serialize bit set, including the cycle that entry pops.
REQ-020 SHALL provide 1-cycle latency accept -> valid_out; no combinational bypass of payload_in.
REQ-021 SHALL drive fu_valid_out[k] = !empty && !flush && head_pending[k]; only the head entry dispatches.
REQ-022 SHALL clear head_pending[k] on the edge where fu_valid_out[k] && fu_ready_in[k].
REQ-023 SHALL drive valid_out = !empty && !flush && (head_pending == 0 || (fu_valid_out & fu_ready_in) covers head_pending).
REQ-024 SHALL pop the head on valid_out && ready_in; count SHALL decrement by one.
REQ-025 SHALL, on simultaneous accept and pop, leave count unchanged; at full, accept is blocked even if popping (REQ-018).
REQ-026 SHALL drive payload_out and fu_sel_out to zero while empty.
REQ-027 SHALL ignore fu_ready_in[k] when fu_valid_out[k] is low.
REQ-028 SHALL, on flush, gate valid_out, fu_valid_out and ready_out low in that cycle and empty the queue at the next edge; flush dominates a simultaneous accept or pop.
REQ-029 SHALL clear all pending masks and serialize bits on flush.

Reset
REQ-030 SHALL, while reset_n low, force pointers, count, pending and serialize bits to 0, regardless of clk.
REQ-031 SHALL, during reset, drive valid_out=0, fu_valid_out=0, ready_out=0, payload_out=0, fu_sel_out=0, count=0.
REQ-032 SHALL drive ready_out=1 in the first cycle after reset_n deasserts when flush=0.
REQ-033 SHALL discard any in-progress dispatch when reset_n asserts mid-operation; payload storage need not be cleared.

Verification
REQ-034 SHALL cover: plain ALU entries A,B with fu_sel_in=0, ready_in=1 -> valid_out rises the cycle after each accept, count 1 -> 1, in-order payload_out.
REQ-035 SHALL cover: DEPTH=2, ready_in=0, three offers -> ready_out=0 after two accepts, count=2; ready_in=1 one cycle -> count=1, ready_out=1 the next cycle.
REQ-036 SHALL cover: head fu_sel=3'b010, fu_ready_in=0 for 3 cycles -> fu_valid_out=3'b010, valid_out=0; fu_ready_in=3'b010 -> valid_out=1 same cycle, fu_valid_out=0 next cycle.
REQ-037 SHALL cover: serialize_in=1 entry accepted -> ready_out=0 until that entry pops, ready_out=1 the cycle after pop.
REQ-038 SHALL cover: count=2 with head pending, flush=1 plus valid_in=1 -> valid_out=fu_valid_out=ready_out=0 that cycle, count=0 next cycle, offered entry not stored.
REQ-039 SHALL cover: reset_n pulsed low mid-dispatch -> all outputs 0 immediately, count=0; 4+ fill/drain cycles confirm pointer wrap-around with no lost or duplicated entry.
